// File: rtl/mash_pkg.sv
// Shared types and constants for the configurable-order MASH modulator.
package mash_pkg;

  localparam int MAX_ORDER_LIMIT = 4;

  typedef logic [1:0] order_t;

  // Fibonacci LFSR x^15 + x^14 + 1, shifting toward the MSB.
  localparam logic [14:0] LFSR_SEED   = 15'h0001;
  localparam int          LFSR_TAP_HI = 14;
  localparam int          LFSR_TAP_LO = 13;

  // An order-N MASH output spans -(2^(N-1)-1)..2^(N-1), so it needs N+1 signed bits.
  function automatic int dac_bw_min(input int order);
    return order + 1;
  endfunction

endpackage

// File: rtl/mash_efm_stage.sv
// First-order error-feedback stage: modular accumulator whose overflow carry is the stage output.
module mash_efm_stage #(
  parameter int WIDTH = 16
) (
  input  logic             aclk,
  input  logic             arst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  logic [WIDTH-1:0] acc;
  logic [WIDTH:0]   full;

  assign full  = {1'b0, acc} + {1'b0, din} + {{WIDTH{1'b0}}, cin};
  assign sum   = full[WIDTH-1:0];
  assign carry = full[WIDTH];

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge aclk) begin
    if (arst) begin
      acc <= '0;
    end else if (en) begin
      acc <= clr ? '0 : sum;
    end
  end

endmodule

// File: rtl/mash_nth.sv
// Configurable-order MASH sigma-delta modulator with AXIS in/out, runtime order select and optional dither.
module mash_nth
  import mash_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int MAX_ORDER = 3,
  parameter int DAC_BW    = 4,
  parameter int DITHER_EN = 0
) (
  input  logic                     aclk,
  input  logic                     arst,
  input  order_t                   cfg_order,
  input  logic [WIDTH-1:0]         s_axis_data_tdata,
  input  logic                     s_axis_data_tvalid,
  output logic                     s_axis_data_tready,
  output logic signed [DAC_BW-1:0] m_axis_data_tdata,
  output logic                     m_axis_data_tvalid,
  input  logic                     m_axis_data_tready
);

  if (MAX_ORDER < 1 || MAX_ORDER > MAX_ORDER_LIMIT || DAC_BW < dac_bw_min(MAX_ORDER)) begin : g_bad_param
    $error("mash_nth: illegal MAX_ORDER/DAC_BW combination");
  end

  localparam order_t ORDER_TOP = order_t'(MAX_ORDER - 1);

  logic                     fire;
  logic                     dither;
  order_t                   order_eff;
  logic [MAX_ORDER-1:0]     active;
  logic [MAX_ORDER-1:0]     carry;
  logic [WIDTH-1:0]         stage_sum [MAX_ORDER];
  logic signed [DAC_BW-1:0] term      [MAX_ORDER];
  logic signed [DAC_BW-1:0] y;
  logic [14:0]              lfsr;

  function automatic logic signed [DAC_BW-1:0] b2s(input logic b);
    return $signed({{(DAC_BW-1){1'b0}}, b});
  endfunction

  assign s_axis_data_tready = arst || !m_axis_data_tvalid || m_axis_data_tready;
  assign fire               = s_axis_data_tvalid && s_axis_data_tready;
  assign dither             = (DITHER_EN != 0) ? lfsr[0] : 1'b0;
  assign order_eff          = (cfg_order > ORDER_TOP) ? ORDER_TOP : cfg_order;

  always_comb begin
    for (int i = 0; i < MAX_ORDER; i++) begin
      active[i] = (i <= int'(order_eff));
    end
  end

  for (genvar s = 0; s < MAX_ORDER; s++) begin : g_stage
    logic [WIDTH-1:0] din;
    logic             cin;

    if (s == 0) begin : g_first
      assign din = s_axis_data_tdata;
      assign cin = dither;
    end else begin : g_next
      assign din = stage_sum[s-1];
      assign cin = 1'b0;
    end

    // Inactive stages are held at zero so re-enabling one starts from a clean state.
    mash_efm_stage #(.WIDTH(WIDTH)) u_stage (
      .aclk  (aclk),
      .arst  (arst),
      .en    (fire),
      .clr   (!active[s]),
      .din   (din),
      .cin   (cin),
      .sum   (stage_sum[s]),
      .carry (carry[s])
    );

    if (s == 0) begin : g_t0
      assign term[s] = b2s(carry[s]);
    end else begin : g_tn
      localparam int HD = s;
      // hist[0] is the carry at the previous fire, hist[HD-1] the oldest.
      logic [HD-1:0] hist;

      always_ff @(posedge aclk) begin
        if (arst) begin
          hist <= '0;
        end else if (fire) begin
          hist <= active[s] ? ((hist << 1) | HD'(carry[s])) : '0;
        end
      end

      // (1 - z^-1)^s applied to this stage's carry stream.
      if (s == 1) begin : g_d1
        assign term[s] = b2s(carry[s]) - b2s(hist[0]);
      end else if (s == 2) begin : g_d2
        assign term[s] = b2s(carry[s]) - b2s(hist[0]) - b2s(hist[0]) + b2s(hist[1]);
      end else begin : g_d3
        assign term[s] = b2s(carry[s])
                       - b2s(hist[0]) - b2s(hist[0]) - b2s(hist[0])
                       + b2s(hist[1]) + b2s(hist[1]) + b2s(hist[1])
                       - b2s(hist[2]);
      end
    end
  end

  // NOTE: y gets a default before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    y = '0;
    for (int i = 0; i < MAX_ORDER; i++) begin
      if (active[i]) begin
        y = y + term[i];
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (arst) begin
      lfsr <= LFSR_SEED;
    end else if (fire) begin
      lfsr <= {lfsr[13:0], lfsr[LFSR_TAP_HI] ^ lfsr[LFSR_TAP_LO]};
    end
  end

  always_ff @(posedge aclk) begin
    if (arst) begin
      m_axis_data_tdata  <= '0;
      m_axis_data_tvalid <= 1'b0;
    end else if (fire) begin
      m_axis_data_tdata  <= y;
      m_axis_data_tvalid <= 1'b1;
    end else if (m_axis_data_tready) begin
      m_axis_data_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mash_nth.sv
// Directed bench for mash_nth: hand-derived output sequences for orders 1..3, stall, reset and order change.
module tb_mash_nth;

  logic              aclk = 1'b0;
  logic              arst;
  logic [1:0]        cfg_order;
  logic [15:0]       s_tdata;
  logic              s_tvalid;
  logic              s_tready;
  logic signed [3:0] m_tdata;
  logic              m_tvalid;
  logic              m_tready;

  int n_err = 0;
  int n_chk = 0;

  mash_nth #(
    .WIDTH     (16),
    .MAX_ORDER (3),
    .DAC_BW    (4),
    .DITHER_EN (0)
  ) dut (
    .aclk               (aclk),
    .arst               (arst),
    .cfg_order          (cfg_order),
    .s_axis_data_tdata  (s_tdata),
    .s_axis_data_tvalid (s_tvalid),
    .s_axis_data_tready (s_tready),
    .m_axis_data_tdata  (m_tdata),
    .m_axis_data_tvalid (m_tvalid),
    .m_axis_data_tready (m_tready)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  // One accepted sample (downstream ready), then check the code produced by that fire.
  task automatic send(input logic [15:0] x, input int exp, input string tag);
    s_tvalid = 1'b1;
    s_tdata  = x;
    @(posedge aclk);
    #1;
    check(tag, 32'($signed(m_tdata)), exp);
    check({tag, "_valid"}, 32'(m_tvalid), 1);
  endtask

  int o2_seq [6] = '{0, 2, 0, 1, 1, 0};
  int o3_seq [6] = '{0, 3, -2, 3, -1, 2};

  initial begin
    arst      = 1'b1;
    cfg_order = 2'd0;
    s_tdata   = '0;
    s_tvalid  = 1'b0;
    m_tready  = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    check("rst_s_tready", 32'(s_tready), 1);
    check("rst_valid", 32'(m_tvalid), 0);
    check("rst_data", 32'($signed(m_tdata)), 0);
    arst = 1'b0;

    // 1st order, half scale: 0,1,0,1,...
    cfg_order = 2'd0;
    for (int i = 0; i < 6; i++) send(16'h8000, i % 2, "o1_half");

    s_tvalid = 1'b0;
    @(posedge aclk);
    #1;
    check("idle_valid_drop", 32'(m_tvalid), 0);

    // 3rd order, zero input
    cfg_order = 2'd2;
    for (int i = 0; i < 8; i++) send(16'h0000, 0, "o3_zero");

    // 2nd order, 3/4 scale, from all-zero state
    cfg_order = 2'd1;
    for (int i = 0; i < 6; i++) send(16'hC000, o2_seq[i], "o2_3q");

    // Reset with a valid output in flight
    arst = 1'b1;
    @(posedge aclk);
    #1;
    check("mid_rst_valid", 32'(m_tvalid), 0);
    check("mid_rst_data", 32'($signed(m_tdata)), 0);
    arst = 1'b0;

    // cfg_order=3 clamps to 3rd order on a 3-stage build
    cfg_order = 2'd3;
    for (int i = 0; i < 6; i++) send(16'hC000, o3_seq[i], "o3_3q");

    // Downstream stall: input blocked, last code (2) held
    m_tready = 1'b0;
    #1;
    check("stall_s_tready", 32'(s_tready), 0);
    for (int i = 0; i < 5; i++) begin
      @(posedge aclk);
      #1;
      check("stall_s_tready_hold", 32'(s_tready), 0);
      check("stall_valid_hold", 32'(m_tvalid), 1);
      check("stall_data_hold", 32'($signed(m_tdata)), 2);
    end
    m_tready = 1'b1;
    send(16'hC000, 0, "post_stall_7");
    send(16'hC000, 1, "post_stall_8");

    // Order change 2 -> 0 -> 2: upper stages restart from zero
    cfg_order = 2'd2;
    send(16'hC000, 0, "chg_o3_a");
    send(16'hC000, 3, "chg_o3_b");
    cfg_order = 2'd0;
    send(16'hC000, 1, "chg_o1_a");
    send(16'hC000, 1, "chg_o1_b");
    cfg_order = 2'd2;
    send(16'hC000, 0, "chg_back_o3_a");
    send(16'hC000, 3, "chg_back_o3_b");
    send(16'hC000, -2, "chg_back_o3_c");

    // Reset pulse, then 1st order half scale restarts 0,1,...
    arst = 1'b1;
    @(posedge aclk);
    #1;
    check("rst2_valid", 32'(m_tvalid), 0);
    arst = 1'b0;
    cfg_order = 2'd0;
    for (int i = 0; i < 4; i++) send(16'h8000, i % 2, "rst2_o1");

    s_tvalid = 1'b0;
    @(posedge aclk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
